// File: rtl/multiport_fifo_pkg.sv
// Package for the multi-lane FWFT FIFO.
// Holds sizing helpers shared by the top level and the lane prefix counter.
package multiport_fifo_pkg;

    // Bits needed to hold a lane count in the range 0..ways.
    function automatic int lane_cnt_w(input int ways);
        return $clog2(ways + 1);
    endfunction

endpackage

// File: rtl/multiport_fifo_lane_prefix_count.sv
// lane_prefix_count: combinational exclusive prefix popcount over lane valids.
// Ports:
//   valid  in   WAYS       per-lane request bits
//   offset out  WAYS x CW  offset[i] = popcount(valid[i-1:0]); lane i at offset[i*CW +: CW]
//   total  out  CW         popcount(valid)
module lane_prefix_count
    import multiport_fifo_pkg::*;
#(
    parameter int WAYS = 2,
    parameter int CW   = lane_cnt_w(WAYS)
) (
    input  logic [WAYS-1:0]    valid,
    output logic [WAYS*CW-1:0] offset,
    output logic [CW-1:0]      total
);

    logic [CW-1:0] acc;

    always_comb begin
        offset = '0;
        acc    = '0;
        for (int i = 0; i < WAYS; i++) begin
            offset[i*CW +: CW] = acc;
            acc                = acc + CW'(valid[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/multiport_fifo.sv
// multiport_fifo: multi-lane synchronous FIFO with first-word-fall-through heads.
// Accepts up to WAYS entries per cycle (holes between valid lanes are compacted)
// and presents up to WAYS head entries per cycle.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   flush         discard all contents (wins over enqueue/dequeue)
//   enq_valid     per-lane write request; enq_data lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   enq_ready     all-or-nothing admission: free slots >= WAYS
//   deq_valid     thermometer, lane i valid when count > i
//   deq_data      head entries, lane i = entry head+i
//   deq_ready     per-lane pop request; only the leading run of ones pops
//   count         occupied entries
//   almost_full   count >= AFULL_THRESH
//   overflow_err  sticky: request seen while enq_ready low; cleared by rst/flush
module multiport_fifo
    import multiport_fifo_pkg::*;
#(
    parameter  int DATA_WIDTH   = 64,
    parameter  int DEPTH        = 16,
    parameter  int WAYS         = 2,
    parameter  int AFULL_THRESH = DEPTH - WAYS,
    localparam int CNT_W        = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [WAYS-1:0]            enq_valid,
    input  logic [WAYS*DATA_WIDTH-1:0] enq_data,
    output logic                       enq_ready,
    output logic [WAYS-1:0]            deq_valid,
    output logic [WAYS*DATA_WIDTH-1:0] deq_data,
    input  logic [WAYS-1:0]            deq_ready,
    output logic [CNT_W-1:0]           count,
    output logic                       almost_full,
    output logic                       overflow_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int LW    = lane_cnt_w(WAYS);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0]      wptr;
    logic [CNT_W-1:0]      rptr;

    logic [WAYS*LW-1:0]    enq_off;
    logic [LW-1:0]         enq_total;
    logic                  enq_fire;
    logic [LW-1:0]         enq_n;
    logic [LW-1:0]         deq_n;

    // Number of consecutive ones starting at lane 0; a hole stops the run.
    function automatic logic [LW-1:0] lead_ones(input logic [WAYS-1:0] v);
        logic [LW-1:0] n;
        logic          run;
        n   = '0;
        run = 1'b1;
        for (int i = 0; i < WAYS; i++) begin
            run = run & v[i];
            if (run) n = n + 1'b1;
        end
        return n;
    endfunction

    lane_prefix_count #(
        .WAYS (WAYS),
        .CW   (LW)
    ) u_prefix (
        .valid  (enq_valid),
        .offset (enq_off),
        .total  (enq_total)
    );

    // Admission looks only at the current count so a same-cycle pop cannot
    // create a combinational path from deq_ready to enq_ready.
    assign enq_ready   = (count <= CNT_W'(DEPTH - WAYS));
    assign almost_full = (count >= CNT_W'(AFULL_THRESH));
    assign enq_fire    = enq_ready && (|enq_valid);
    assign enq_n       = enq_fire ? enq_total : '0;
    assign deq_n       = lead_ones(deq_ready & deq_valid);

    always_comb begin
        deq_valid = '0;
        deq_data  = '0;
        for (int i = 0; i < WAYS; i++) begin
            deq_valid[i]                           = (count > CNT_W'(i));
            deq_data[i*DATA_WIDTH +: DATA_WIDTH]   = mem[IDX_W'(rptr + CNT_W'(i))];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else begin
            wptr  <= wptr + CNT_W'(enq_n);
            rptr  <= rptr + CNT_W'(deq_n);
            count <= count + CNT_W'(enq_n) - CNT_W'(deq_n);
            if ((|enq_valid) && !enq_ready) overflow_err <= 1'b1;
        end
    end

    // Storage has no reset; the low pointer bits wrap modulo DEPTH naturally.
    always_ff @(posedge clk) begin
        if (enq_fire && !flush && !rst) begin
            for (int i = 0; i < WAYS; i++) begin
                if (enq_valid[i])
                    mem[IDX_W'(wptr + CNT_W'(enq_off[i*LW +: LW]))] <= enq_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_multiport_fifo.sv
module tb_multiport_fifo;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int WAYS  = 2;
    localparam int CNT_W = 4;
    localparam int AF    = DEPTH - WAYS;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic [WAYS-1:0]  enq_valid = '0;
    logic [WAYS*DW-1:0] enq_data = '0;
    logic             enq_ready;
    logic [WAYS-1:0]  deq_valid;
    logic [WAYS*DW-1:0] deq_data;
    logic [WAYS-1:0]  deq_ready = '0;
    logic [CNT_W-1:0] count;
    logic             almost_full;
    logic             overflow_err;

    multiport_fifo #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .WAYS         (WAYS),
        .AFULL_THRESH (AF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .enq_valid    (enq_valid),
        .enq_data     (enq_data),
        .enq_ready    (enq_ready),
        .deq_valid    (deq_valid),
        .deq_data     (deq_data),
        .deq_ready    (deq_ready),
        .count        (count),
        .almost_full  (almost_full),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: plain queue of entries in FIFO order plus sticky flag.
    logic [DW-1:0] mq[$];
    logic          m_ovf = 1'b0;

    typedef struct {
        logic [1:0]  ev;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [1:0]  dr;
        logic        fl;
        int          cnt;
        logic [1:0]  dv;
        logic [15:0] h0;
        logic [15:0] h1;
        logic        rdy;
        logic        af;
        logic        ov;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step(input logic [1:0] ev, input logic [31:0] ed,
                              input logic [1:0] dr, input logic fl);
        int cnt;
        int k;
        bit rdy;
        cnt = mq.size();
        rdy = (DEPTH - cnt) >= WAYS;
        k = 0;
        for (int i = 0; i < WAYS; i++)
            if (dr[i] && cnt > i && k == i) k++;
        if (fl) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            for (int i = 0; i < k; i++) void'(mq.pop_front());
            if (ev != 0) begin
                if (rdy) begin
                    for (int i = 0; i < WAYS; i++)
                        if (ev[i]) mq.push_back(ed[i*DW +: DW]);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        int n;
        n = mq.size();
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".enq_ready"}, 32'(enq_ready), 32'((DEPTH - n) >= WAYS));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(n >= AF));
        chk({tag, ".overflow_err"}, 32'(overflow_err), 32'(m_ovf));
        for (int i = 0; i < WAYS; i++) begin
            chk({tag, ".deq_valid"}, 32'(deq_valid[i]), 32'(n > i));
            if (n > i) chk({tag, ".deq_data"}, 32'(deq_data[i*DW +: DW]), 32'(mq[i]));
        end
    endtask

    task automatic cycle(input logic [1:0] ev, input logic [31:0] ed,
                         input logic [1:0] dr, input logic fl, input logic r);
        enq_valid = ev;
        enq_data  = ed;
        deq_ready = dr;
        flush     = fl;
        rst       = r;
        @(posedge clk);
        model_step(ev, ed, dr, fl | r);
        @(negedge clk);
        enq_valid = '0;
        deq_ready = '0;
        flush     = 1'b0;
        rst       = 1'b0;
    endtask

    initial begin
        //         ev     d0        d1        dr     fl  cnt dv     h0        h1        rdy af ov
        tv.push_back('{2'b11, 16'h00A0, 16'h00B0, 2'b00, 0, 2, 2'b11, 16'h00A0, 16'h00B0, 1, 0, 0});
        tv.push_back('{2'b00, 16'h0000, 16'h0000, 2'b11, 0, 0, 2'b00, 16'h0000, 16'h0000, 1, 0, 0});
        tv.push_back('{2'b10, 16'hFFFF, 16'h00C0, 2'b00, 0, 1, 2'b01, 16'h00C0, 16'h0000, 1, 0, 0});
        tv.push_back('{2'b11, 16'h00D0, 16'h00E0, 2'b00, 0, 3, 2'b11, 16'h00C0, 16'h00D0, 1, 0, 0});
        tv.push_back('{2'b00, 16'h0000, 16'h0000, 2'b01, 0, 2, 2'b11, 16'h00D0, 16'h00E0, 1, 0, 0});
        tv.push_back('{2'b00, 16'h0000, 16'h0000, 2'b10, 0, 2, 2'b11, 16'h00D0, 16'h00E0, 1, 0, 0});
        tv.push_back('{2'b11, 16'h00F0, 16'h00F1, 2'b11, 0, 2, 2'b11, 16'h00F0, 16'h00F1, 1, 0, 0});
        tv.push_back('{2'b11, 16'h00F2, 16'h00F3, 2'b00, 0, 4, 2'b11, 16'h00F0, 16'h00F1, 1, 0, 0});
        tv.push_back('{2'b11, 16'h00F4, 16'h00F5, 2'b00, 0, 6, 2'b11, 16'h00F0, 16'h00F1, 1, 1, 0});
        tv.push_back('{2'b01, 16'h00F6, 16'h1234, 2'b00, 0, 7, 2'b11, 16'h00F0, 16'h00F1, 0, 1, 0});
        tv.push_back('{2'b01, 16'h00F7, 16'h0000, 2'b00, 0, 7, 2'b11, 16'h00F0, 16'h00F1, 0, 1, 1});
        tv.push_back('{2'b11, 16'h00F8, 16'h00F9, 2'b00, 0, 7, 2'b11, 16'h00F0, 16'h00F1, 0, 1, 1});
        tv.push_back('{2'b00, 16'h0000, 16'h0000, 2'b11, 0, 5, 2'b11, 16'h00F2, 16'h00F3, 1, 0, 1});
        tv.push_back('{2'b11, 16'h0099, 16'h0098, 2'b11, 1, 0, 2'b00, 16'h0000, 16'h0000, 1, 0, 0});
        tv.push_back('{2'b01, 16'h00C1, 16'h0000, 2'b00, 0, 1, 2'b01, 16'h00C1, 16'h0000, 1, 0, 0});
        tv.push_back('{2'b11, 16'h00C2, 16'h00C3, 2'b00, 0, 3, 2'b11, 16'h00C1, 16'h00C2, 1, 0, 0});
        tv.push_back('{2'b11, 16'h00C4, 16'h00C5, 2'b11, 0, 3, 2'b11, 16'h00C3, 16'h00C4, 1, 0, 0});
        tv.push_back('{2'b00, 16'h0000, 16'h0000, 2'b11, 0, 1, 2'b01, 16'h00C5, 16'h0000, 1, 0, 0});
        tv.push_back('{2'b00, 16'h0000, 16'h0000, 2'b01, 0, 0, 2'b00, 16'h0000, 16'h0000, 1, 0, 0});
        tv.push_back('{2'b01, 16'h0060, 16'h0000, 2'b00, 0, 1, 2'b01, 16'h0060, 16'h0000, 1, 0, 0});
        tv.push_back('{2'b00, 16'h0000, 16'h0000, 2'b01, 0, 0, 2'b00, 16'h0000, 16'h0000, 1, 0, 0});
        tv.push_back('{2'b01, 16'h0070, 16'h0000, 2'b00, 0, 1, 2'b01, 16'h0070, 16'h0000, 1, 0, 0});
        tv.push_back('{2'b11, 16'h0071, 16'h0072, 2'b00, 0, 3, 2'b11, 16'h0070, 16'h0071, 1, 0, 0});
        tv.push_back('{2'b00, 16'h0000, 16'h0000, 2'b01, 0, 2, 2'b11, 16'h0071, 16'h0072, 1, 0, 0});
        tv.push_back('{2'b11, 16'h0073, 16'h0074, 2'b11, 0, 2, 2'b11, 16'h0073, 16'h0074, 1, 0, 0});
        tv.push_back('{2'b00, 16'h0000, 16'h0000, 2'b11, 0, 0, 2'b00, 16'h0000, 16'h0000, 1, 0, 0});

        cycle(2'b00, 32'h0, 2'b00, 1'b0, 1'b1);
        cycle(2'b00, 32'h0, 2'b00, 1'b0, 1'b1);
        chk("reset.count", 32'(count), 32'd0);
        chk("reset.deq_valid", 32'(deq_valid), 32'd0);
        chk("reset.enq_ready", 32'(enq_ready), 32'd1);
        chk("reset.almost_full", 32'(almost_full), 32'd0);
        chk("reset.overflow_err", 32'(overflow_err), 32'd0);

        foreach (tv[v]) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            cycle(tv[v].ev, {tv[v].d1, tv[v].d0}, tv[v].dr, tv[v].fl, 1'b0);
            chk({tag, ".count"}, 32'(count), 32'(tv[v].cnt));
            chk({tag, ".deq_valid"}, 32'(deq_valid), 32'(tv[v].dv));
            if (tv[v].dv[0]) chk({tag, ".head0"}, 32'(deq_data[DW-1:0]), 32'(tv[v].h0));
            if (tv[v].dv[1]) chk({tag, ".head1"}, 32'(deq_data[2*DW-1:DW]), 32'(tv[v].h1));
            chk({tag, ".enq_ready"}, 32'(enq_ready), 32'(tv[v].rdy));
            chk({tag, ".almost_full"}, 32'(almost_full), 32'(tv[v].af));
            chk({tag, ".overflow_err"}, 32'(overflow_err), 32'(tv[v].ov));
        end

        // Fill to completely full, overflow, then reset mid-stream.
        for (int i = 0; i < 4; i++) begin
            cycle(2'b11, {16'(16'h0200 + 2*i + 1), 16'(16'h0200 + 2*i)}, 2'b00, 1'b0, 1'b0);
            check_model("fill");
        end
        chk("full.count", 32'(count), 32'd8);
        chk("full.enq_ready", 32'(enq_ready), 32'd0);
        cycle(2'b01, 32'h0000_0BAD, 2'b00, 1'b0, 1'b0);
        chk("full.overflow_err", 32'(overflow_err), 32'd1);
        check_model("ovf");
        cycle(2'b11, 32'h1111_2222, 2'b11, 1'b0, 1'b1);
        chk("midrst.count", 32'(count), 32'd0);
        chk("midrst.overflow_err", 32'(overflow_err), 32'd0);
        chk("midrst.deq_valid", 32'(deq_valid), 32'd0);
        check_model("midrst");

        // Randomized traffic alternating fill-biased and drain-biased phases.
        for (int c = 0; c < 3000; c++) begin
            logic [1:0] ev;
            logic [1:0] dr;
            logic       fl;
            ev = 2'($urandom_range(0, 3));
            if (((c / 64) % 2) == 0)
                dr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            else
                dr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            fl = ($urandom_range(0, 59) == 0);
            cycle(ev, $urandom, dr, fl, 1'b0);
            check_model("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
